tabuleiro_ultimate: RTL and testbench

Parametrised board-state engine for ultimate tic-tac-toe with an N×N macro board of N×N micro boards. It accepts one-hot jogadas, validates them, stores cell ownership, and sequentially scans the affected micro board and then the macro board for win or draw. It outputs the macro state, the next target board, the free-choice flag and end-of-game. It sits between the jogada-capture datapath and the control unit, and replaces the fixed 3×3 macro/micro registers and the constant fim_jogo.

---
 rtl/tabuleiro_pkg.sv | 55 +++++
 rtl/varredor_linhas.sv | 39 +++
 rtl/tabuleiro_ultimate.sv | 216 +++++++++++++++++++++
 tb/tb_tabuleiro_ultimate.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tabuleiro_pkg.sv
// Shared cell codes, FSM state encoding and line/one-hot helpers for the
// ultimate tic-tac-toe board engine.
package tabuleiro_pkg;

   localparam int MAXC = 64;

   localparam logic [1:0] VAZIO  = 2'b00;
   localparam logic [1:0] X      = 2'b01;
   localparam logic [1:0] O      = 2'b10;
   localparam logic [1:0] EMPATE = 2'b11;

   typedef enum logic [3:0] {
      OCIOSO,
      VALIDA,
      REJEITA,
      ESCREVE,
      VARRE_MICRO,
      ATUALIZA_MACRO,
      VARRE_MACRO,
      CONCLUI,
      FIM
   } estado_t;

   // Lines 0..n-1 are rows, n..2n-1 columns, 2n the main and 2n+1 the anti diagonal.
   function automatic logic [MAXC-1:0] line_mask(input int n, input int k);
      logic [MAXC-1:0] m;
      m = '0;
      for (int i = 0; i < n; i++) begin
         if (k < n)
            m[k*n + i] = 1'b1;
         else if (k < 2*n)
            m[i*n + (k - n)] = 1'b1;
         else if (k == 2*n)
            m[i*n + i] = 1'b1;
         else
            m[i*n + (n - 1 - i)] = 1'b1;
      end
      return m;
   endfunction

   function automatic logic is_onehot(input logic [MAXC-1:0] v);
      logic seen;
      logic multi;
      seen  = 1'b0;
      multi = 1'b0;
      for (int i = 0; i < MAXC; i++) begin
         if (v[i]) begin
            multi = multi | seen;
            seen  = 1'b1;
         end
      end
      return seen & ~multi;
   endfunction

endpackage

// File: rtl/varredor_linhas.sv
// Combinational line checker: reports whether the selected line of a board
// is fully owned by the given player and whether every cell is occupied.
module varredor_linhas import tabuleiro_pkg::*; #(
   parameter int N = 3,
   localparam int C = N*N,
   localparam int L = 2*N + 2,
   localparam int LW = $clog2(L),
   localparam int LP = 1 << LW
) (
   input  logic [2*C-1:0] board_i,
   input  logic [LW-1:0]  line_i,
   input  logic [1:0]     player_i,
   output logic           line_won_o,
   output logic           all_full_o
);

   logic [L-1:0]  wonLine;
   logic [LP-1:0] wonPad;
   logic [C-1:0]  cellFull;

   for (genvar k = 0; k < L; k++) begin : gLine
      localparam logic [C-1:0] MASK = C'(line_mask(N, k));
      logic [C-1:0] match;
      for (genvar c = 0; c < C; c++) begin : gCell
         assign match[c] = ~MASK[c] | (board_i[2*c +: 2] == player_i);
      end
      assign wonLine[k] = &match;
   end

   for (genvar c = 0; c < C; c++) begin : gFull
      assign cellFull[c] = |board_i[2*c +: 2];
   end

   // Padding keeps the line index in range when L is not a power of two.
   assign wonPad     = LP'(wonLine);
   assign line_won_o = wonPad[line_i];
   assign all_full_o = &cellFull;

endmodule

// File: rtl/tabuleiro_ultimate.sv
// Ultimate tic-tac-toe board engine: validates one-hot moves, stores cells,
// then scans the touched micro board and, if it closed, the macro board.
module tabuleiro_ultimate import tabuleiro_pkg::*; #(
   parameter int N = 3,
   localparam int C = N*N,
   localparam int L = 2*N + 2,
   localparam int LW = $clog2(L)
) (
   input  logic           clock,
   input  logic           reset,
   input  logic           jogada,
   input  logic           jogador,
   input  logic [C-1:0]   macro_sel,
   input  logic [C-1:0]   micro_sel,
   input  logic [C-1:0]   rd_macro,
   input  logic [C-1:0]   rd_micro,
   output logic [1:0]     rd_celula,
   output logic           pronto,
   output logic           aceita,
   output logic           rejeitada,
   output logic [2*C-1:0] estado_macro,
   output logic [C-1:0]   prox_macro,
   output logic           escolhe_macro,
   output logic           fim_jogo,
   output logic [1:0]     vencedor
);

   estado_t                estadoFsm_q;
   logic [C-1:0][2*C-1:0]  celulas_q;
   logic [2*C-1:0]         estadoMacro_q;
   logic [C-1:0]           macroSel_q, microSel_q, prox_q;
   logic                   jogador_q, escolhe_q, fim_q, won_q;
   logic                   pronto_q, aceita_q, rejeitada_q;
   logic [1:0]             vencedor_q, codigoMicro_q;
   logic [LW-1:0]          cnt_q;

   logic [2*C-1:0] microBoard;
   logic [1:0]     alvoMacro, alvoCelula, estadoNoMicro, rdCell, codigo;
   logic           wonMicro, cheioMicro, wonMacro, cheioMacro, valida, ultimaLinha;

   // One-hot selections become AND-OR muxes over the stored boards.
   always_comb begin
      microBoard    = '0;
      alvoMacro     = '0;
      alvoCelula    = '0;
      estadoNoMicro = '0;
      rdCell        = '0;
      for (int b = 0; b < C; b++) begin
         if (macroSel_q[b]) begin
            microBoard = microBoard | celulas_q[b];
            alvoMacro  = alvoMacro | estadoMacro_q[2*b +: 2];
         end
         if (microSel_q[b])
            estadoNoMicro = estadoNoMicro | estadoMacro_q[2*b +: 2];
         for (int c = 0; c < C; c++) begin
            if (rd_macro[b] && rd_micro[c])
               rdCell = rdCell | celulas_q[b][2*c +: 2];
         end
      end
      for (int c = 0; c < C; c++) begin
         if (microSel_q[c])
            alvoCelula = alvoCelula | microBoard[2*c +: 2];
      end
   end

   assign codigo      = jogador_q ? O : X;
   assign ultimaLinha = (cnt_q == LW'(L - 1));
   assign valida      = is_onehot(MAXC'(macroSel_q)) && is_onehot(MAXC'(microSel_q))
                        && (alvoMacro == VAZIO) && (alvoCelula == VAZIO)
                        && (escolhe_q || (macroSel_q == prox_q));

   varredor_linhas #(.N(N)) uMicro (
      .board_i   (microBoard),
      .line_i    (cnt_q),
      .player_i  (codigo),
      .line_won_o(wonMicro),
      .all_full_o(cheioMicro)
   );

   varredor_linhas #(.N(N)) uMacro (
      .board_i   (estadoMacro_q),
      .line_i    (cnt_q),
      .player_i  (codigo),
      .line_won_o(wonMacro),
      .all_full_o(cheioMacro)
   );

   // Control FSM; pulse and ready flags are registered with the state change.
   always_ff @(posedge clock) begin
      if (!reset) begin
         estadoFsm_q   <= OCIOSO;
         celulas_q     <= '0;
         estadoMacro_q <= '0;
         macroSel_q    <= '0;
         microSel_q    <= '0;
         prox_q        <= '0;
         jogador_q     <= 1'b0;
         escolhe_q     <= 1'b1;
         fim_q         <= 1'b0;
         won_q         <= 1'b0;
         vencedor_q    <= VAZIO;
         codigoMicro_q <= VAZIO;
         cnt_q         <= '0;
         pronto_q      <= 1'b1;
         aceita_q      <= 1'b0;
         rejeitada_q   <= 1'b0;
      end else begin
         pronto_q    <= 1'b0;
         aceita_q    <= 1'b0;
         rejeitada_q <= 1'b0;
         case (estadoFsm_q)
            OCIOSO: begin
               if (jogada) begin
                  macroSel_q  <= macro_sel;
                  microSel_q  <= micro_sel;
                  jogador_q   <= jogador;
                  estadoFsm_q <= VALIDA;
               end else begin
                  pronto_q <= 1'b1;
               end
            end
            VALIDA: begin
               if (valida) begin
                  estadoFsm_q <= ESCREVE;
               end else begin
                  estadoFsm_q <= REJEITA;
                  rejeitada_q <= 1'b1;
               end
            end
            REJEITA: begin
               estadoFsm_q <= OCIOSO;
               pronto_q    <= 1'b1;
            end
            ESCREVE: begin
               for (int b = 0; b < C; b++) begin
                  for (int c = 0; c < C; c++) begin
                     if (macroSel_q[b] && microSel_q[c])
                        celulas_q[b][2*c +: 2] <= codigo;
                  end
               end
               cnt_q       <= '0;
               won_q       <= 1'b0;
               estadoFsm_q <= VARRE_MICRO;
            end
            VARRE_MICRO: begin
               cnt_q <= cnt_q + LW'(1);
               won_q <= won_q | wonMicro;
               if (ultimaLinha) begin
                  if (won_q | wonMicro) begin
                     codigoMicro_q <= codigo;
                     estadoFsm_q   <= ATUALIZA_MACRO;
                  end else if (cheioMicro) begin
                     codigoMicro_q <= EMPATE;
                     estadoFsm_q   <= ATUALIZA_MACRO;
                  end else begin
                     estadoFsm_q <= CONCLUI;
                     aceita_q    <= 1'b1;
                  end
               end
            end
            ATUALIZA_MACRO: begin
               for (int b = 0; b < C; b++) begin
                  if (macroSel_q[b])
                     estadoMacro_q[2*b +: 2] <= codigoMicro_q;
               end
               cnt_q       <= '0;
               won_q       <= 1'b0;
               estadoFsm_q <= VARRE_MACRO;
            end
            VARRE_MACRO: begin
               cnt_q <= cnt_q + LW'(1);
               won_q <= won_q | wonMacro;
               if (ultimaLinha) begin
                  if (won_q | wonMacro) begin
                     fim_q      <= 1'b1;
                     vencedor_q <= codigo;
                  end else if (cheioMacro) begin
                     fim_q      <= 1'b1;
                     vencedor_q <= EMPATE;
                  end
                  estadoFsm_q <= CONCLUI;
                  aceita_q    <= 1'b1;
               end
            end
            CONCLUI: begin
               prox_q    <= microSel_q;
               escolhe_q <= (estadoNoMicro != VAZIO);
               if (fim_q) begin
                  estadoFsm_q <= FIM;
               end else begin
                  estadoFsm_q <= OCIOSO;
                  pronto_q    <= 1'b1;
               end
            end
            FIM: begin
               estadoFsm_q <= FIM;
            end
            default: begin
               estadoFsm_q <= OCIOSO;
               pronto_q    <= 1'b1;
            end
         endcase
      end
   end

   assign rd_celula     = (is_onehot(MAXC'(rd_macro)) && is_onehot(MAXC'(rd_micro))) ? rdCell : VAZIO;
   assign pronto        = pronto_q;
   assign aceita        = aceita_q;
   assign rejeitada     = rejeitada_q;
   assign estado_macro  = estadoMacro_q;
   assign prox_macro    = prox_q;
   assign escolhe_macro = escolhe_q;
   assign fim_jogo      = fim_q;
   assign vencedor      = vencedor_q;

endmodule

// File: tb/tb_tabuleiro_ultimate.sv
// Randomized self-checking bench for tabuleiro_ultimate against a
// coordinate-based model of the ultimate tic-tac-toe rules.
module tb_tabuleiro_ultimate;

   localparam int N = 3;
   localparam int C = N*N;
   localparam int L = 2*N + 2;

   logic           clock = 1'b0;
   logic           reset = 1'b0;
   logic           jogada = 1'b0;
   logic           jogador = 1'b0;
   logic [C-1:0]   macro_sel = '0, micro_sel = '0, rd_macro = '0, rd_micro = '0;
   logic [1:0]     rd_celula, vencedor;
   logic           pronto, aceita, rejeitada, escolhe_macro, fim_jogo;
   logic [2*C-1:0] estado_macro;
   logic [C-1:0]   prox_macro;

   int checks = 0;
   int errors = 0;

   int cel[C][C];
   int est[C];
   int prox;
   bit escolhe, fim;
   int venc;

   tabuleiro_ultimate #(.N(N)) dut (
      .clock(clock), .reset(reset), .jogada(jogada), .jogador(jogador),
      .macro_sel(macro_sel), .micro_sel(micro_sel),
      .rd_macro(rd_macro), .rd_micro(rd_micro), .rd_celula(rd_celula),
      .pronto(pronto), .aceita(aceita), .rejeitada(rejeitada),
      .estado_macro(estado_macro), .prox_macro(prox_macro),
      .escolhe_macro(escolhe_macro), .fim_jogo(fim_jogo), .vencedor(vencedor)
   );

   always #5 clock = ~clock;

   initial begin
      #900000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference model: boards addressed by index, lines by row/column coordinates.
   function automatic int valAt(input int b, input int i);
      return (b < 0) ? est[i] : cel[b][i];
   endfunction

   function automatic bit wonBy(input int b, input int p);
      bit any, r, cc, d1, d2;
      any = 0; d1 = 1; d2 = 1;
      for (int k = 0; k < N; k++) begin
         r = 1; cc = 1;
         for (int i = 0; i < N; i++) begin
            if (valAt(b, k*N + i) != p) r = 0;
            if (valAt(b, i*N + k) != p) cc = 0;
         end
         any = any | r | cc;
         if (valAt(b, k*N + k) != p) d1 = 0;
         if (valAt(b, k*N + (N - 1 - k)) != p) d2 = 0;
      end
      return any | d1 | d2;
   endfunction

   function automatic bit fullAt(input int b);
      for (int i = 0; i < C; i++)
         if (valAt(b, i) == 0) return 0;
      return 1;
   endfunction

   function automatic int idxOf(input logic [C-1:0] v);
      for (int i = 0; i < C; i++)
         if (v[i]) return i;
      return -1;
   endfunction

   function automatic logic [C-1:0] oh(input int i);
      logic [C-1:0] r;
      r = '0;
      r[i] = 1'b1;
      return r;
   endfunction

   function automatic logic [2*C-1:0] expMacro();
      logic [2*C-1:0] r;
      for (int b = 0; b < C; b++) r[2*b +: 2] = 2'(est[b]);
      return r;
   endfunction

   function automatic logic [C-1:0] expProx();
      return (prox < 0) ? '0 : oh(prox);
   endfunction

   task automatic modelReset();
      for (int b = 0; b < C; b++) begin
         est[b] = 0;
         for (int c = 0; c < C; c++) cel[b][c] = 0;
      end
      prox = -1; escolhe = 1; fim = 0; venc = 0;
   endtask

   task automatic modelMove(input logic [C-1:0] ms, input logic [C-1:0] cs, input logic pl,
                            output int lat, output bit ok);
      int b, c, p;
      bit closed;
      ok = 0; lat = 2;
      if ($countones(ms) != 1 || $countones(cs) != 1) return;
      b = idxOf(ms); c = idxOf(cs);
      if (est[b] != 0 || cel[b][c] != 0) return;
      if (!escolhe && b != prox) return;
      ok = 1; p = pl ? 2 : 1; cel[b][c] = p; closed = 0; lat = 3 + L;
      if (wonBy(b, p)) begin est[b] = p; closed = 1; end
      else if (fullAt(b)) begin est[b] = 3; closed = 1; end
      if (closed) begin
         lat = 4 + 2*L;
         if (wonBy(-1, p)) begin fim = 1; venc = p; end
         else if (fullAt(-1)) begin fim = 1; venc = 3; end
      end
      prox = c;
      escolhe = (est[c] != 0);
   endtask

   task automatic checkState(input string tag);
      checkOutput({tag, ".estado_macro"}, 64'(estado_macro), 64'(expMacro()));
      checkOutput({tag, ".prox_macro"}, 64'(prox_macro), 64'(expProx()));
      checkOutput({tag, ".escolhe"}, 64'(escolhe_macro), 64'(escolhe));
      checkOutput({tag, ".fim"}, 64'(fim_jogo), 64'(fim));
      checkOutput({tag, ".vencedor"}, 64'(vencedor), 64'(venc));
      checkOutput({tag, ".pronto"}, 64'(pronto), 64'(!fim));
   endtask

   task automatic checkReset(input string tag);
      checkState(tag);
      checkOutput({tag, ".pulsos"}, 64'({aceita, rejeitada}), 64'(0));
      rd_macro = oh($urandom_range(0, C-1));
      rd_micro = oh($urandom_range(0, C-1));
      #1 checkOutput({tag, ".rd"}, 64'(rd_celula), 64'(0));
   endtask

   task automatic resetDut();
      @(negedge clock) reset = 1'b0;
      @(posedge clock);
      @(negedge clock) reset = 1'b1;
      modelReset();
      checkReset("reset");
   endtask

   // Drives one request; abortAt>0 pulls reset that many cycles in on a long evaluation.
   task automatic applyStimulus(input logic [C-1:0] ms, input logic [C-1:0] cs, input logic pl,
                                input int abortAt, output bit aborted);
      int lat, cyc, r1, r2;
      bit ok;
      logic gotA, gotR;
      aborted = 0;
      if (fim) begin
         jogada = 1'b1; macro_sel = ms; micro_sel = cs; jogador = pl;
         @(posedge clock);
         #1 jogada = 1'b0;
         cyc = 0;
         repeat (25) begin
            @(negedge clock);
            if (aceita || rejeitada || pronto) cyc++;
         end
         checkOutput("fimIgnora", 64'(cyc), 64'(0));
         checkState("fim");
         return;
      end
      checkOutput("prontoAntes", 64'(pronto), 64'(1));
      modelMove(ms, cs, pl, lat, ok);
      jogada = 1'b1; macro_sel = ms; micro_sel = cs; jogador = pl;
      @(posedge clock);
      #1;
      jogada = 1'b0;
      macro_sel = C'($urandom); micro_sel = C'($urandom); jogador = 1'($urandom);
      cyc = 0; gotA = 0; gotR = 0;
      while (!gotA && !gotR && cyc < 40) begin
         @(negedge clock);
         cyc++;
         if (abortAt > 0 && ok && lat > abortAt && cyc == abortAt) begin
            reset = 1'b0;
            @(posedge clock);
            @(negedge clock);
            modelReset();
            checkReset("abortMeio");
            reset = 1'b1;
            aborted = 1;
            return;
         end
         gotA = aceita; gotR = rejeitada;
      end
      checkOutput("latencia", 64'(cyc), 64'(lat));
      checkOutput("aceita", 64'(gotA), 64'(ok));
      checkOutput("rejeitada", 64'(gotR), 64'(!ok));
      @(negedge clock);
      checkOutput("pulso", 64'({aceita, rejeitada}), 64'(0));
      checkState("mov");
      if (ok) begin
         rd_macro = ms; rd_micro = cs;
         #1 checkOutput("rdJogada", 64'(rd_celula), 64'(pl ? 2 : 1));
      end
      r1 = $urandom_range(0, C-1); r2 = $urandom_range(0, C-1);
      rd_macro = oh(r1); rd_micro = oh(r2);
      #1 checkOutput("rdAleatorio", 64'(rd_celula), 64'(cel[r1][r2]));
   endtask

   task automatic playGame(input bit abortMode, output bit aborted);
      int q[$];
      int pick;
      logic pl;
      bit ab;
      pl = 1'b0; aborted = 0;
      for (int m = 0; m < 120 && !fim; m++) begin
         if ($urandom_range(0, 7) == 0) begin
            applyStimulus(C'($urandom), C'($urandom), pl, 0, ab);
            continue;
         end
         q.delete();
         for (int b = 0; b < C; b++)
            for (int c = 0; c < C; c++)
               if (est[b] == 0 && cel[b][c] == 0 && (escolhe || b == prox)) q.push_back(b*C + c);
         if (q.size() == 0) break;
         pick = q[$urandom_range(0, q.size() - 1)];
         applyStimulus(oh(pick / C), oh(pick % C), pl, abortMode ? 15 : 0, ab);
         if (ab) begin
            aborted = 1;
            return;
         end
         pl = ~pl;
      end
   endtask

   initial begin
      bit ab;
      reset = 1'b0;
      repeat (2) @(posedge clock);
      @(negedge clock) reset = 1'b1;
      modelReset();
      checkReset("inicio");

      applyStimulus(oh(4), oh(0), 1'b0, 0, ab);
      applyStimulus(oh(2), oh(0), 1'b1, 0, ab);
      applyStimulus(oh(0), oh(4), 1'b1, 0, ab);
      applyStimulus(oh(4), oh(1), 1'b0, 0, ab);
      applyStimulus(oh(1), oh(4), 1'b1, 0, ab);
      applyStimulus(oh(4), oh(2), 1'b0, 0, ab);
      applyStimulus(oh(2) | oh(3), oh(0), 1'b1, 0, ab);
      applyStimulus(oh(2), '0, 1'b1, 0, ab);
      applyStimulus(oh(2), oh(4), 1'b1, 0, ab);
      applyStimulus(oh(4), oh(5), 1'b0, 0, ab);
      applyStimulus(oh(3), oh(0), 1'b0, 0, ab);
      applyStimulus(oh(0), oh(4), 1'b1, 0, ab);

      rd_macro = oh(4) | oh(0); rd_micro = oh(0);
      #1 checkOutput("rdNaoOneHot", 64'(rd_celula), 64'(0));
      rd_macro = oh(4); rd_micro = '0;
      #1 checkOutput("rdZero", 64'(rd_celula), 64'(0));

      for (int g = 0; g < 5; g++) begin
         playGame(g == 1, ab);
         if (fim) begin
            applyStimulus(oh(0), oh(0), 1'b0, 0, ab);
            applyStimulus(oh(C-1), oh(2), 1'b1, 0, ab);
         end
         resetDut();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
